// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetch requests, buffers in-order
// responses tagged with their PCs, and presents one instruction per cycle to IF/ID.
module fetch_prefetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // In-flight counters cover up to 16*DEPTH-1 requests, i.e. several back-to-back
    // redirects against a slow memory before the old stream has drained.
    localparam int unsigned OUT_W = PTR_W + 4;

    localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [INSTR_W-1:0] NOP        = INSTR_W'(32'h0000_0013);
    localparam logic [PC_W-1:0]    ALIGN_MASK = ~PC_W'(3);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    slot_pc    [DEPTH];
    logic [INSTR_W-1:0] slot_instr [DEPTH];
    logic [DEPTH-1:0]   slot_filled;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   fill_ptr;
    logic [CNT_W-1:0]   alloc_cnt;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   discard;

    logic               req_fire;
    logic               rsp_fire;
    logic               rsp_drop;
    logic               rsp_fill;
    logic               deq_fire;
    logic [CNT_W-1:0]   alloc_nxt;
    logic [OUT_W-1:0]   outstanding_nxt;

    // Request side and IF/ID outputs are pure functions of registered state.
    always_comb begin
        imem_req_valid = !rst && (alloc_cnt < FULL_CNT);
        imem_req_addr  = fetch_pc;
        if_valid       = !rst && (alloc_cnt != '0) && slot_filled[head];
        if_instr       = if_valid ? slot_instr[head] : NOP;
        if_pc          = if_valid ? slot_pc[head] : '0;
    end

    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        rsp_fire = imem_rsp_valid && (outstanding != '0);
        rsp_drop = rsp_fire && (discard != '0);
        rsp_fill = rsp_fire && (discard == '0) && !redirect_valid;
        deq_fire = if_valid && !stall && !redirect_valid;
    end

    // NOTE: each next-value starts from a default so no path leaves it unassigned (no latch).
    always_comb begin
        alloc_nxt = alloc_cnt;
        if (req_fire && !deq_fire) begin
            alloc_nxt = alloc_cnt + 1'b1;
        end else if (!req_fire && deq_fire) begin
            alloc_nxt = alloc_cnt - 1'b1;
        end
    end

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !rsp_fire) begin
            outstanding_nxt = outstanding + 1'b1;
        end else if (!req_fire && rsp_fire) begin
            outstanding_nxt = outstanding - 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            slot_filled <= '0;
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            alloc_cnt   <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight, including a request accepted now,
            // belongs to the old stream and is dropped on return.
            fetch_pc    <= redirect_pc & ALIGN_MASK;
            slot_filled <= '0;
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            alloc_cnt   <= '0;
            outstanding <= outstanding_nxt;
            discard     <= outstanding_nxt;
        end else begin
            alloc_cnt   <= alloc_nxt;
            outstanding <= outstanding_nxt;
            if (rsp_drop) begin
                discard <= discard - 1'b1;
            end
            if (deq_fire) begin
                slot_filled[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (req_fire) begin
                slot_filled[tail] <= 1'b0;
                tail              <= tail + 1'b1;
                fetch_pc          <= fetch_pc + PC_W'(4);
            end
            if (rsp_fill) begin
                slot_filled[fill_ptr] <= 1'b1;
                fill_ptr              <= fill_ptr + 1'b1;
            end
        end
    end

    // NOTE: slot payload has no reset; slot_filled and alloc_cnt gate every read of it.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            slot_pc[tail] <= fetch_pc;
        end
        if (rsp_fill) begin
            slot_instr[fill_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses to an instruction memory over a valid/ready request channel with variable response latency.
- Buffers returned instructions, tagged with their PCs, in an in-order slot queue.
- Presents one instruction per cycle to IF/ID, honouring the hazard-unit stall and the branch redirect/flush from ID.

Parameters:
- DEPTH, 4, number of queue slots (power of two, >=2); also the max in-flight plus buffered instructions.
- PC_W, 64, PC and address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- redirect_valid  in  1  taken branch from ID; flush and restart fetch.
- redirect_pc  in  PC_W  new fetch target; bits [1:0] are forced to 0.
- stall  in  1  hazard-unit hold; IF/ID does not consume this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  PC_W  byte address of the requested word.
- imem_rsp_valid  in  1  response valid; responses return strictly in request order, with no backpressure.
- imem_rsp_data  in  INSTR_W  returned instruction.
- if_valid  out  1  head slot holds a returned instruction.
- if_instr  out  INSTR_W  head instruction; 32'h00000013 (NOP) when if_valid=0.
- if_pc  out  PC_W  PC of the head instruction; 0 when if_valid=0.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - fetch_pc=RESET_PC; all slots free; head, tail, outstanding and discard counters = 0.
  - Outputs while in reset and the following cycle before any request issues: imem_req_valid=0 during rst; if_valid=0; if_instr=NOP; if_pc=0.
  - Reset mid-operation abandons all state. Responses to pre-reset requests are NOT guaranteed to be dropped; the bench resets the memory model together with this block.
- Slot allocation:
  - imem_req_valid = !rst && (allocated < DEPTH); imem_req_addr = fetch_pc.
  - A request handshake (valid && ready) allocates slot[tail], stores its pc, clears the filled bit, advances tail mod DEPTH, sets fetch_pc += 4 and increments outstanding.
- Response:
  - If discard>0: the data is dropped, discard and outstanding both decrement, no slot is written.
  - Otherwise: slot at fill pointer gets the instruction, its filled bit is set, the fill pointer advances and outstanding decrements.
  - A response with outstanding=0 is ignored.
- Dequeue: when if_valid && !stall, the head slot is freed and head advances. Outputs come from head slot contents and are combinational from registered state.
- Redirect (priority over every other event in the same cycle):
  - All slots are freed; head, tail and fill pointers reset to 0.
  - fetch_pc = {redirect_pc[PC_W-1:2],2'b00}.
  - discard = outstanding + (request handshake this cycle) - (response this cycle). Every in-flight response, including one accepted this cycle, belongs to the old stream and is dropped.
  - No dequeue and no fill occur that cycle.
  - imem_req_valid may be 1 in the redirect cycle; a handshake then counts toward discard.
- Full: allocated==DEPTH holds imem_req_valid=0. A same-cycle dequeue does not re-enable the request in that cycle; there is no bypass and the request issues next cycle.
- Empty / pass-through: the earliest path is request at N, response at N+1, if_valid at N+2. There is no response-to-output bypass.
- Throughput: with a 1-cycle memory and no stall, one instruction per cycle sustained for DEPTH>=3.
- Wrap-around: pointers wrap mod DEPTH. fetch_pc wraps naturally at 2^PC_W.
- Stall: holds the head. Fetching continues until the queue is full, so the queue absorbs stalls without losing instructions.

Test Plan:
- Reset, 1-cycle memory returning addr as data, no stall -> first request addr 0x0. if_pc sequence 0x0,0x4,0x8,... one per cycle from the third cycle after rst deasserts. if_instr matches memory.
- stall held 6 cycles with head pc=0x8 -> if_pc stays 0x8. imem_req_valid drops after DEPTH=4 slots are allocated. On release, 0x8,0xC,0x10,0x14 are delivered back-to-back with no gaps or duplicates.
- Memory latency 3 cycles, redirect_pc=0x103 while 3 requests are in flight -> 3 responses dropped. Next request addr 0x100. if_pc=0x100 appears with no stale instruction in between.
- Redirect in the same cycle as a request handshake and a response -> the accepted request's response is dropped. discard counts correctly; next delivered if_pc = redirect target.
- imem_req_ready low for 5 cycles with the queue empty -> if_valid=0, if_instr=0x00000013, imem_req_addr stable at its current value. Fetch resumes at the same address when ready rises.
- Assert rst mid-stream with 2 filled slots -> next cycle if_valid=0, if_pc=0. First post-reset request addr = RESET_PC.
